ysyx_23060240_csr_unit: RTL and testbench
=========================================

# ysyx_23060240_csr_unit

Execute-stage initiator for the CSR register file: accepts one decoded CSR/ecall/mret instruction over a valid/ready handshake and sequences the read, read-modify-write and trap strobes into the CSR file. Returns the old CSR value for `rd` writeback, or a PC redirect target for `ecall`/`mret`, to the downstream writeback/PC logic. Strictly one instruction in flight.

## Interface

Parameters:
- `XLEN`, 32, data/PC width

Ports:
- `clk`  in  1  clock, rising-edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decoded instruction present
- `in_ready`  out  1  unit idle, accepts instruction
- `is_csr` / `is_ecall` / `is_mret`  in  1 each  instruction class
- `funct3`  in  3  CSR op encoding
- `csr_addr`  in  12  target CSR
- `rs1_idx`  in  5  rs1 index; zimm for immediate forms
- `rs1_data`  in  XLEN  rs1 value
- `pc`  in  XLEN  instruction PC
- `r_csr_en`, `r_csr_addr[11:0]`  out  CSR read request
- `r_csr_data`  in  XLEN  combinational read data
- `w_csr_en`, `w_csr_addr[11:0]`, `w_csr_data[XLEN-1:0]`  out  CSR write request
- `jump_ecall`, `jump_mret`  out  1 each  trap strobes
- `csr_pc`  out  XLEN  PC presented to CSR file for mepc capture
- `out_valid`  out  1  result present; `out_ready`  in  1  consumer accepts
- `rd_we`  out  1; `rd_wdata`  out  XLEN  writeback
- `redirect_valid`  out  1; `redirect_pc`  out  XLEN  next PC
- `illegal`  out  1  unsupported CSR address (see Configuration)

## Operation

- FSM: IDLE -> READ -> WRITE -> RESP -> IDLE. `in_ready` = (state == IDLE).
- Accept when `in_valid && in_ready`; latch all inputs. Class priority if several set: ecall > mret > csr. None set: return to IDLE, no output.
- READ: `r_csr_en`=1; address = `csr_addr` (CSR), 0x305 mtvec (ecall), 0x341 mepc (mret). Latch `r_csr_data` as `old`.
- WRITE, CSR ops: new = RW: src; RS: old|src; RC: old&~src; src = `rs1_data` (001/010/011) or zero-extended `rs1_idx` (101/110/111). RW/RWI always write; RS/RC/RSI/RCI write only if `rs1_idx` != 0. funct3 000/100: no write.
- WRITE, ecall: `jump_ecall`=1, `csr_pc`=latched pc. mret: `jump_mret`=1.
- RESP: `out_valid`=1 until `out_ready`. CSR: `rd_we`=1, `rd_wdata`=old, `redirect_valid`=0. ecall/mret: `rd_we`=0, `redirect_valid`=1, `redirect_pc`=old. Handshake returns to IDLE.

## Timing

- Accept edge T0; READ cycle T1; WRITE cycle T2; earliest `out_valid` T3; next accept earliest the cycle after handshake.
- All CSR-side strobes exactly one full cycle, registered outputs, stable across the falling edge at which the CSR file commits.
- Outputs stay stable while `out_valid && !out_ready`; no further CSR strobes.
- Reset: state IDLE; every output 0 (`in_ready` becomes 1 after reset deasserts). Reset in any state aborts with no pending write or trap strobe.
- `in_valid` while busy ignored (`in_ready`=0).

## Configuration

- `YSYX_23060240_CSR_ADDR_CHECK_EN` defined: addresses other than 0x300/0x305/0x341/0x342 skip the write, `illegal`=1 with `out_valid`, `rd_we`=0.
- Undefined: no check; `illegal` tied 0; all addresses forwarded.

## Structure

- Package `ysyx_23060240_csr_pkg`: CSR address constants, funct3 encodings, FSM state enum.
- Sub-module `ysyx_23060240_csr_alu`: combinational new-value and write-enable from funct3/old/src/rs1_idx.

## Test plan

- CSRRW 0x305, rs1_data=0x8000_0100, CSR holds 0 -> `w_csr_en` at T2 with data 0x8000_0100; `rd_wdata`=0 at T3.
- CSRRS 0x300 rs1_idx=0, mstatus=0x1800 -> no `w_csr_en`; `rd_wdata`=0x1800.
- CSRRCI 0x341 zimm=0x3, mepc=0xF -> write 0xC; `rd_wdata`=0xF.
- ecall at pc=0x8000_0010, mtvec=0x8000_0200 -> `jump_ecall` one cycle with `csr_pc`=0x8000_0010; `redirect_pc`=0x8000_0200, `rd_we`=0.
- mret, mepc=0x8000_0014, `out_ready` low 3 cycles -> `redirect_pc`=0x8000_0014 held stable, single `jump_mret`.
- `rst` asserted during WRITE -> next cycle all outputs 0, no commit; with CHECK_EN, CSRRW to 0x7C0 -> `illegal`=1, no write.

Source files
------------

// File: rtl/ysyx_23060240_csr_pkg.sv
// Shared definitions for the CSR execute unit: CSR addresses, funct3
// encodings, FSM states, instruction classes and small decode helpers.
package ysyx_23060240_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } csr_state_e;

   typedef enum logic [1:0] {
      CLS_NONE,
      CLS_CSR,
      CLS_ECALL,
      CLS_MRET
   } csr_cls_e;

   // ecall wins over mret, mret wins over a plain CSR op.
   function automatic csr_cls_e decode_cls(input logic ecall, input logic mret,
                                           input logic csr);
      if (ecall) return CLS_ECALL;
      if (mret)  return CLS_MRET;
      if (csr)   return CLS_CSR;
      return CLS_NONE;
   endfunction

   // Addresses actually implemented by the CSR file.
   function automatic logic csr_addr_supported(input logic [11:0] addr);
      return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
             (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
   endfunction

endpackage

// File: rtl/ysyx_23060240_csr_alu.sv
// Combinational new-value / write-enable computation for Zicsr ops.
// Set/clear forms with rs1_idx == 0 read only and must not write.
module ysyx_23060240_csr_alu
   import ysyx_23060240_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [4:0]      rs1_idx,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] old_val,
   output logic [XLEN-1:0] new_val,
   output logic            wr_en
);

   logic [XLEN-1:0] src;

   // Pick the source operand and apply the read-modify-write rule.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      src     = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
      new_val = old_val;
      wr_en   = 1'b0;
      case (funct3)
         F3_CSRRW, F3_CSRRWI: begin
            new_val = src;
            wr_en   = 1'b1;
         end
         F3_CSRRS, F3_CSRRSI: begin
            new_val = old_val | src;
            wr_en   = (rs1_idx != 5'd0);
         end
         F3_CSRRC, F3_CSRRCI: begin
            new_val = old_val & ~src;
            wr_en   = (rs1_idx != 5'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_23060240_csr_unit.sv
// CSR execute unit: takes one CSR/ecall/mret instruction, sequences the
// read, write and trap strobes to the CSR file, then returns the old value
// (rd writeback) or a redirect target. One instruction in flight.
// Optional: define YSYX_23060240_CSR_ADDR_CHECK_EN to flag and suppress
// accesses to unimplemented CSR addresses.
module ysyx_23060240_csr_unit
   import ysyx_23060240_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_csr,
   input  logic            is_ecall,
   input  logic            is_mret,
   input  logic [2:0]      funct3,
   input  logic [11:0]     csr_addr,
   input  logic [4:0]      rs1_idx,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] pc,
   output logic            r_csr_en,
   output logic [11:0]     r_csr_addr,
   input  logic [XLEN-1:0] r_csr_data,
   output logic            w_csr_en,
   output logic [11:0]     w_csr_addr,
   output logic [XLEN-1:0] w_csr_data,
   output logic            jump_ecall,
   output logic            jump_mret,
   output logic [XLEN-1:0] csr_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            rd_we,
   output logic [XLEN-1:0] rd_wdata,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            illegal
);

   csr_state_e      state_q, state_d;
   csr_cls_e        cls_q, cls_d, in_cls;
   logic [2:0]      funct3_q, funct3_d;
   logic [11:0]     csr_addr_q, csr_addr_d;
   logic [4:0]      rs1_idx_q, rs1_idx_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] old_q, old_d;

   logic            r_csr_en_q, r_csr_en_d;
   logic [11:0]     r_csr_addr_q, r_csr_addr_d;
   logic            w_csr_en_q, w_csr_en_d;
   logic [11:0]     w_csr_addr_q, w_csr_addr_d;
   logic [XLEN-1:0] w_csr_data_q, w_csr_data_d;
   logic            jump_ecall_q, jump_ecall_d;
   logic            jump_mret_q, jump_mret_d;
   logic [XLEN-1:0] csr_pc_q, csr_pc_d;
   logic            out_valid_q, out_valid_d;
   logic            rd_we_q, rd_we_d;
   logic [XLEN-1:0] rd_wdata_q, rd_wdata_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            illegal_q, illegal_d;

   logic            accept;
   logic            addr_ok;
   logic [XLEN-1:0] alu_new_val;
   logic            alu_wr_en;

   assign in_cls = decode_cls(is_ecall, is_mret, is_csr);
   assign accept = in_valid && in_ready;

`ifdef YSYX_23060240_CSR_ADDR_CHECK_EN
   assign addr_ok = csr_addr_supported(csr_addr_q);
`else
   assign addr_ok = 1'b1;
`endif

   // The ALU sees the live read data during READ so the write value can be
   // registered straight into the WRITE-cycle strobe.
   ysyx_23060240_csr_alu #(.XLEN(XLEN)) u_alu (
      .funct3   (funct3_q),
      .rs1_idx  (rs1_idx_q),
      .rs1_data (rs1_data_q),
      .old_val  (r_csr_data),
      .new_val  (alu_new_val),
      .wr_en    (alu_wr_en)
   );

   // State and registered outputs; reset drops any pending strobe.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q          <= ST_IDLE;
         cls_q            <= CLS_NONE;
         funct3_q         <= '0;
         csr_addr_q       <= '0;
         rs1_idx_q        <= '0;
         rs1_data_q       <= '0;
         pc_q             <= '0;
         old_q            <= '0;
         r_csr_en_q       <= 1'b0;
         r_csr_addr_q     <= '0;
         w_csr_en_q       <= 1'b0;
         w_csr_addr_q     <= '0;
         w_csr_data_q     <= '0;
         jump_ecall_q     <= 1'b0;
         jump_mret_q      <= 1'b0;
         csr_pc_q         <= '0;
         out_valid_q      <= 1'b0;
         rd_we_q          <= 1'b0;
         rd_wdata_q       <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         illegal_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         cls_q            <= cls_d;
         funct3_q         <= funct3_d;
         csr_addr_q       <= csr_addr_d;
         rs1_idx_q        <= rs1_idx_d;
         rs1_data_q       <= rs1_data_d;
         pc_q             <= pc_d;
         old_q            <= old_d;
         r_csr_en_q       <= r_csr_en_d;
         r_csr_addr_q     <= r_csr_addr_d;
         w_csr_en_q       <= w_csr_en_d;
         w_csr_addr_q     <= w_csr_addr_d;
         w_csr_data_q     <= w_csr_data_d;
         jump_ecall_q     <= jump_ecall_d;
         jump_mret_q      <= jump_mret_d;
         csr_pc_q         <= csr_pc_d;
         out_valid_q      <= out_valid_d;
         rd_we_q          <= rd_we_d;
         rd_wdata_q       <= rd_wdata_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         illegal_q        <= illegal_d;
      end
   end

   // Next state: a classless instruction is accepted but leaves us in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept && (in_cls != CLS_NONE)) state_d = ST_READ;
         ST_READ:  state_d = ST_WRITE;
         ST_WRITE: state_d = ST_RESP;
         ST_RESP:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Next values of the latched instruction and of every registered output.
   always_comb begin
      cls_d            = cls_q;
      funct3_d         = funct3_q;
      csr_addr_d       = csr_addr_q;
      rs1_idx_d        = rs1_idx_q;
      rs1_data_d       = rs1_data_q;
      pc_d             = pc_q;
      old_d            = old_q;
      r_csr_en_d       = 1'b0;
      r_csr_addr_d     = '0;
      w_csr_en_d       = 1'b0;
      w_csr_addr_d     = '0;
      w_csr_data_d     = '0;
      jump_ecall_d     = 1'b0;
      jump_mret_d      = 1'b0;
      csr_pc_d         = '0;
      out_valid_d      = out_valid_q;
      rd_we_d          = rd_we_q;
      rd_wdata_d       = rd_wdata_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      illegal_d        = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cls_d      = in_cls;
               funct3_d   = funct3;
               csr_addr_d = csr_addr;
               rs1_idx_d  = rs1_idx;
               rs1_data_d = rs1_data;
               pc_d       = pc;
               r_csr_en_d = (in_cls != CLS_NONE);
               case (in_cls)
                  CLS_ECALL: r_csr_addr_d = CSR_MTVEC;
                  CLS_MRET:  r_csr_addr_d = CSR_MEPC;
                  default:   r_csr_addr_d = csr_addr;
               endcase
            end
         end
         ST_READ: begin
            old_d = r_csr_data;
            case (cls_q)
               CLS_CSR: begin
                  w_csr_en_d   = alu_wr_en && addr_ok;
                  w_csr_addr_d = csr_addr_q;
                  w_csr_data_d = alu_new_val;
               end
               CLS_ECALL: begin
                  jump_ecall_d = 1'b1;
                  csr_pc_d     = pc_q;
               end
               CLS_MRET: jump_mret_d = 1'b1;
               default: ;
            endcase
         end
         ST_WRITE: begin
            out_valid_d = 1'b1;
            if (cls_q == CLS_CSR) begin
               rd_we_d          = addr_ok;
               rd_wdata_d       = old_q;
               redirect_valid_d = 1'b0;
               illegal_d        = !addr_ok;
            end else begin
               rd_we_d          = 1'b0;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = old_q;
            end
         end
         ST_RESP: begin
            if (out_ready) begin
               out_valid_d      = 1'b0;
               rd_we_d          = 1'b0;
               rd_wdata_d       = '0;
               redirect_valid_d = 1'b0;
               redirect_pc_d    = '0;
               illegal_d        = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // While reset is held every output reads 0, so a strobe caught mid-cycle
   // by reset never commits at the CSR file's falling edge.
   assign in_ready       = !rst && (state_q == ST_IDLE);
   assign r_csr_en       = !rst && r_csr_en_q;
   assign r_csr_addr     = rst ? '0 : r_csr_addr_q;
   assign w_csr_en       = !rst && w_csr_en_q;
   assign w_csr_addr     = rst ? '0 : w_csr_addr_q;
   assign w_csr_data     = rst ? '0 : w_csr_data_q;
   assign jump_ecall     = !rst && jump_ecall_q;
   assign jump_mret      = !rst && jump_mret_q;
   assign csr_pc         = rst ? '0 : csr_pc_q;
   assign out_valid      = !rst && out_valid_q;
   assign rd_we          = !rst && rd_we_q;
   assign rd_wdata       = rst ? '0 : rd_wdata_q;
   assign redirect_valid = !rst && redirect_valid_q;
   assign redirect_pc    = rst ? '0 : redirect_pc_q;
   assign illegal        = !rst && illegal_q;

endmodule

// File: tb/tb_ysyx_23060240_csr_unit.sv
// Self-checking bench for ysyx_23060240_csr_unit. A CSR-file model answers
// reads and commits writes on the falling edge; a transaction-level model
// predicts each cycle's outputs, and directed tests pin literal results.
module tb_ysyx_23060240_csr_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        is_csr = 1'b0, is_ecall = 1'b0, is_mret = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [11:0] csr_addr = '0;
   logic [4:0]  rs1_idx = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] pc = '0;
   logic        r_csr_en;
   logic [11:0] r_csr_addr;
   logic [31:0] r_csr_data;
   logic        w_csr_en;
   logic [11:0] w_csr_addr;
   logic [31:0] w_csr_data;
   logic        jump_ecall, jump_mret;
   logic [31:0] csr_pc;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        rd_we;
   logic [31:0] rd_wdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   ysyx_23060240_csr_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .is_csr(is_csr), .is_ecall(is_ecall), .is_mret(is_mret),
      .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx),
      .rs1_data(rs1_data), .pc(pc),
      .r_csr_en(r_csr_en), .r_csr_addr(r_csr_addr), .r_csr_data(r_csr_data),
      .w_csr_en(w_csr_en), .w_csr_addr(w_csr_addr), .w_csr_data(w_csr_data),
      .jump_ecall(jump_ecall), .jump_mret(jump_mret), .csr_pc(csr_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .rd_we(rd_we), .rd_wdata(rd_wdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- CSR file model ----------------
   logic [31:0] csr_mem [0:4095];
   bit          mem_init_done = 1'b0;
   int          n_ecall = 0;
   int          n_mret  = 0;

   assign r_csr_data = csr_mem[r_csr_addr];

   always @(negedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
         mem_init_done = 1'b1;
      end
      if (w_csr_en) csr_mem[w_csr_addr] = w_csr_data;
      if (jump_ecall) n_ecall++;
      if (jump_mret) n_mret++;
   end

   // ---------------- transaction model ----------------
   typedef struct {
      int          cls;    // 0 csr op, 1 ecall, 2 mret
      logic [11:0] raddr;
      logic [31:0] old;
      bit          we;
      logic [11:0] waddr;
      logic [31:0] wdata;
      bit          ill;
      logic [31:0] pc;
   } exp_t;

   exp_t tr;
   int   phase = 0;  // 0 idle, 1 read, 2 write, 3 response

   function automatic exp_t predict(input logic e, input logic m,
                                    input logic [2:0] f3, input logic [11:0] a,
                                    input logic [4:0] idx, input logic [31:0] d,
                                    input logic [31:0] p);
      exp_t        t;
      logic [31:0] src;
      t.cls   = e ? 1 : (m ? 2 : 0);
      t.raddr = e ? 12'h305 : (m ? 12'h341 : a);
      t.old   = csr_mem[t.raddr];
      t.pc    = p;
      t.waddr = a;
      t.we    = 1'b0;
      t.wdata = 32'd0;
      t.ill   = 1'b0;
      src     = (f3 >= 3'd5) ? 32'(idx) : d;
      if (t.cls == 0) begin
         if (f3 == 3'd1 || f3 == 3'd5) begin
            t.we = 1'b1; t.wdata = src;
         end else if (f3 == 3'd2 || f3 == 3'd6) begin
            t.we = (idx != 0); t.wdata = t.old | src;
         end else if (f3 == 3'd3 || f3 == 3'd7) begin
            t.we = (idx != 0); t.wdata = t.old & ~src;
         end
`ifdef YSYX_23060240_CSR_ADDR_CHECK_EN
         if (a != 12'h300 && a != 12'h305 && a != 12'h341 && a != 12'h342) begin
            t.ill = 1'b1;
            t.we  = 1'b0;
         end
`endif
      end
      return t;
   endfunction

   // Compare every cycle on the falling edge, then advance the model to the
   // cycle after the coming rising edge.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_strobes", {23'd0, in_ready, r_csr_en, w_csr_en, jump_ecall,
                               jump_mret, out_valid, rd_we, redirect_valid,
                               illegal}, 32'd0);
         check("rst_addr", {8'd0, r_csr_addr, w_csr_addr}, 32'd0);
         check("rst_data", w_csr_data | csr_pc | rd_wdata | redirect_pc, 32'd0);
         phase = 0;
      end else begin
         check("in_ready", in_ready, phase == 0);
         check("r_csr_en", r_csr_en, phase == 1);
         if (phase == 1) check("r_csr_addr", r_csr_addr, tr.raddr);
         check("w_csr_en", w_csr_en, phase == 2 && tr.cls == 0 && tr.we);
         if (phase == 2 && tr.cls == 0 && tr.we) begin
            check("w_csr_addr", w_csr_addr, tr.waddr);
            check("w_csr_data", w_csr_data, tr.wdata);
         end
         check("jump_ecall", jump_ecall, phase == 2 && tr.cls == 1);
         if (phase == 2 && tr.cls == 1) check("csr_pc", csr_pc, tr.pc);
         check("jump_mret", jump_mret, phase == 2 && tr.cls == 2);
         check("out_valid", out_valid, phase == 3);
         check("rd_we", rd_we, phase == 3 && tr.cls == 0 && !tr.ill);
         check("redirect_valid", redirect_valid, phase == 3 && tr.cls != 0);
         check("illegal", illegal, phase == 3 && tr.ill);
         if (phase == 3) begin
            if (tr.cls == 0) check("rd_wdata", rd_wdata, tr.old);
            else             check("redirect_pc", redirect_pc, tr.old);
         end
         case (phase)
            0: if (in_valid && (is_csr || is_ecall || is_mret)) begin
                  tr    = predict(is_ecall, is_mret, funct3, csr_addr, rs1_idx,
                                  rs1_data, pc);
                  phase = 1;
               end
            1: phase = 2;
            2: phase = 3;
            3: if (out_ready) phase = 0;
            default: phase = 0;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a rising edge with the unit idle; returns the same way.
   task automatic do_instr(input logic e, input logic m, input logic c,
                           input logic [2:0] f3, input logic [11:0] a,
                           input logic [4:0] idx, input logic [31:0] d,
                           input logic [31:0] p, input int dly, input bit poke,
                           output logic [31:0] wd, output logic [31:0] rp,
                           output logic ill);
      is_ecall = e; is_mret = m; is_csr = c;
      funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d; pc = p;
      in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      check("accept_wait", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; is_csr = 1'b0;
      out_ready = (dly == 0);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check("resp_wait", out_valid, 1'b1);
      wd = rd_wdata; rp = redirect_pc; ill = illegal;
      for (int k = 0; k < dly; k++) begin
         @(posedge clk); #1;
         if (poke && k == 0) begin
            in_valid = 1'b1; is_csr = 1'b1; funct3 = 3'b001;
            csr_addr = 12'h300; rs1_idx = 5'd1; rs1_data = 32'hBAD0_BAD0;
         end
      end
      if (dly > 0) begin
         out_ready = 1'b1; in_valid = 1'b0; is_csr = 1'b0;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [31:0] wd, rp;
   logic        il;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Preload mstatus = 0x1800 and mepc = 0xF.
      do_instr(0, 0, 1, 3'b001, 12'h300, 5'd1, 32'h0000_1800, 32'h0, 0, 0, wd, rp, il);
      do_instr(0, 0, 1, 3'b001, 12'h341, 5'd1, 32'h0000_000F, 32'h0, 0, 0, wd, rp, il);

      // CSRRW mtvec with CSR at 0.
      do_instr(0, 0, 1, 3'b001, 12'h305, 5'd1, 32'h8000_0100, 32'h0, 0, 0, wd, rp, il);
      check("csrrw_rd", wd, 32'h0);
      check("csrrw_mem", csr_mem[12'h305], 32'h8000_0100);

      // CSRRS with rs1 = x0: read only.
      do_instr(0, 0, 1, 3'b010, 12'h300, 5'd0, 32'h0000_FFFF, 32'h0, 0, 0, wd, rp, il);
      check("csrrs_x0_rd", wd, 32'h0000_1800);
      check("csrrs_x0_mem", csr_mem[12'h300], 32'h0000_1800);

      // CSRRCI mepc, zimm = 3.
      do_instr(0, 0, 1, 3'b111, 12'h341, 5'd3, 32'hFFFF_FFFF, 32'h0, 0, 0, wd, rp, il);
      check("csrrci_rd", wd, 32'h0000_000F);
      check("csrrci_mem", csr_mem[12'h341], 32'h0000_000C);

      // Set mtvec, then ecall.
      do_instr(0, 0, 1, 3'b001, 12'h305, 5'd2, 32'h8000_0200, 32'h0, 0, 0, wd, rp, il);
      check("mtvec_rd", wd, 32'h8000_0100);
      do_instr(1, 0, 0, 3'b000, 12'h000, 5'd0, 32'h0, 32'h8000_0010, 0, 0, wd, rp, il);
      check("ecall_redirect", rp, 32'h8000_0200);
      check("ecall_mtvec_kept", csr_mem[12'h305], 32'h8000_0200);

      // Set mepc, then mret with out_ready held low and a busy-time in_valid.
      do_instr(0, 0, 1, 3'b001, 12'h341, 5'd4, 32'h8000_0014, 32'h0, 0, 0, wd, rp, il);
      check("mepc_rd", wd, 32'h0000_000C);
      do_instr(0, 1, 0, 3'b000, 12'h000, 5'd0, 32'h0, 32'h0, 3, 1, wd, rp, il);
      check("mret_redirect", rp, 32'h8000_0014);
      check("busy_poke_ignored", csr_mem[12'h300], 32'h0000_1800);

      // CSRRSI and CSRRC on mstatus.
      do_instr(0, 0, 1, 3'b110, 12'h300, 5'd5, 32'h0, 32'h0, 0, 0, wd, rp, il);
      check("csrrsi_rd", wd, 32'h0000_1800);
      check("csrrsi_mem", csr_mem[12'h300], 32'h0000_1805);
      do_instr(0, 0, 1, 3'b011, 12'h300, 5'd7, 32'h0000_1000, 32'h0, 1, 0, wd, rp, il);
      check("csrrc_rd", wd, 32'h0000_1805);
      check("csrrc_mem", csr_mem[12'h300], 32'h0000_0805);

      // funct3 000 never writes.
      do_instr(0, 0, 1, 3'b000, 12'h342, 5'd9, 32'h0000_0055, 32'h0, 0, 0, wd, rp, il);
      check("f3_000_rd", wd, 32'h0);
      check("f3_000_mem", csr_mem[12'h342], 32'h0);

      // in_valid with no class set: nothing happens.
      in_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h342; rs1_data = 32'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("noclass_mem", csr_mem[12'h342], 32'h0);

      // All classes set: ecall wins.
      do_instr(1, 1, 1, 3'b001, 12'h300, 5'd1, 32'h0000_AAAA, 32'h8000_0020, 0, 0, wd, rp, il);
      check("prio_redirect", rp, 32'h8000_0200);
      check("prio_mem", csr_mem[12'h300], 32'h0000_0805);

      // Reset during the WRITE cycle aborts the write.
      is_csr = 1'b1; funct3 = 3'b001; csr_addr = 12'h342; rs1_idx = 5'd1;
      rs1_data = 32'h0000_DEAD; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; is_csr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_abort_mem", csr_mem[12'h342], 32'h0);

      // Unit works again after the abort.
      do_instr(0, 0, 1, 3'b101, 12'h342, 5'd31, 32'h0, 32'h0, 0, 0, wd, rp, il);
      check("csrrwi_rd", wd, 32'h0);
      check("csrrwi_mem", csr_mem[12'h342], 32'h0000_001F);

      // Unimplemented address.
      do_instr(0, 0, 1, 3'b001, 12'h7C0, 5'd1, 32'h0000_1234, 32'h0, 0, 0, wd, rp, il);
`ifdef YSYX_23060240_CSR_ADDR_CHECK_EN
      check("unimpl_illegal", il, 1'b1);
      check("unimpl_mem", csr_mem[12'h7C0], 32'h0);
`else
      check("unimpl_illegal", il, 1'b0);
      check("unimpl_mem", csr_mem[12'h7C0], 32'h0000_1234);
`endif

      repeat (3) @(posedge clk);
      check("ecall_pulses", n_ecall, 2);
      check("mret_pulses", n_mret, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
